// File: rtl/alu_defs_pkg.sv
// alu_defs: 4-bit ALU control encodings shared by ALU control, the execute stage and its bench.
// Revision: 1.0
`default_nettype none

package alu_defs;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_MULA = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_ADDU = 4'b1000;
  localparam logic [3:0] ALU_SUBU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1110;

  // Two's-complement overflow from operand and result sign bits.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    if (is_sub) return (a_msb != b_msb) && (r_msb != a_msb);
    else        return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: 32x32 unsigned iterative multiplier, one partial product per step.
// Revision: 1.0
`default_nettype none

module shift_add_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product,
  output logic        last
);

  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_prod;
  logic [4:0]  r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= 64'h0;
      r_mplier <= 32'h0;
      r_prod   <= 64'h0;
      r_cnt    <= 5'd0;
    end else if (start) begin
      r_mcand  <= {32'h0, a};
      r_mplier <= b;
      r_prod   <= 64'h0;
      r_cnt    <= 5'd0;
    end else if (step) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
    end
  end

  assign product = r_prod;
  assign last    = step && (r_cnt == 5'd31);

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute stage; MULA multiply-accumulate into HI/LO when ALU_MULA_EN is defined.
// Revision: 1.0
`default_nettype none

module alu_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] bus_a,
  input  logic [31:0] bus_b,
  input  logic [4:0]  shamt,
  input  logic        acc_clr,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  import alu_defs::*;

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_alu_result;
  logic        w_alu_ovf;

  assign w_sum  = bus_a + bus_b;
  assign w_diff = bus_a - bus_b;

  always_comb begin
    w_alu_result = 32'h0;
    w_alu_ovf    = 1'b0;
    case (alu_ctrl)
      ALU_AND:  w_alu_result = bus_a & bus_b;
      ALU_OR:   w_alu_result = bus_a | bus_b;
      ALU_ADD: begin
        w_alu_result = w_sum;
        w_alu_ovf    = signed_ovf(bus_a[31], bus_b[31], w_sum[31], 1'b0);
      end
      ALU_SLL:  w_alu_result = bus_b << shamt;
      ALU_SRL:  w_alu_result = bus_b >> shamt;
      ALU_SUB: begin
        w_alu_result = w_diff;
        w_alu_ovf    = signed_ovf(bus_a[31], bus_b[31], w_diff[31], 1'b1);
      end
      ALU_SLT:  w_alu_result = {31'h0, $signed(bus_a) < $signed(bus_b)};
      ALU_ADDU: w_alu_result = w_sum;
      ALU_SUBU: w_alu_result = w_diff;
      ALU_XOR:  w_alu_result = bus_a ^ bus_b;
      ALU_SLTU: w_alu_result = {31'h0, bus_a < bus_b};
      ALU_NOR:  w_alu_result = ~(bus_a | bus_b);
      ALU_SRA:  w_alu_result = $signed(bus_b) >>> shamt;
      ALU_LUI:  w_alu_result = {bus_b[15:0], 16'h0};
      default:  w_alu_result = 32'h0;  // MULA in the single-cycle path and unused 1111
    endcase
  end

`ifdef ALU_MULA_EN
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_mul_start;
  logic        w_step;
  logic        w_last;
  logic [63:0] w_product;
  logic [63:0] w_acc;

  assign w_mul_start = (r_state == S_IDLE) && start && (alu_ctrl == ALU_MULA);
  assign w_step      = (r_state == S_MUL);
  assign w_acc       = {r_hi, r_lo} + w_product;

  shift_add_multiplier u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (w_mul_start),
    .step    (w_step),
    .a       (bus_a),
    .b       (bus_b),
    .product (w_product),
    .last    (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      result   <= 32'h0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      done     <= 1'b0;
      r_hi     <= 32'h0;
      r_lo     <= 32'h0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Clearing here precedes a same-cycle MULA, whose accumulate is 33 cycles away.
          if (acc_clr) begin
            r_hi <= 32'h0;
            r_lo <= 32'h0;
          end
          if (start) begin
            if (alu_ctrl == ALU_MULA) begin
              r_state <= S_MUL;
            end else begin
              result   <= w_alu_result;
              zero     <= (w_alu_result == 32'h0);
              overflow <= w_alu_ovf;
              done     <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (w_last) r_state <= S_ACC;
        end
        S_ACC: begin
          r_hi     <= w_acc[63:32];
          r_lo     <= w_acc[31:0];
          result   <= w_acc[31:0];
          zero     <= (w_acc[31:0] == 32'h0);
          overflow <= 1'b0;
          done     <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= 32'h0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        result   <= w_alu_result;
        zero     <= (w_alu_result == 32'h0);
        overflow <= w_alu_ovf;
        done     <= 1'b1;
      end
    end
  end

  assign busy = 1'b0;
  assign hi   = 32'h0;
  assign lo   = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors feeding a scoreboard queue, checked by a Done-driven monitor.
// Revision: 1.0
`default_nettype none

module tb_alu_exec_unit;

  import alu_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_ctrl = 4'h0;
  logic [31:0] bus_a = 32'h0;
  logic [31:0] bus_b = 32'h0;
  logic [4:0]  shamt = 5'h0;
  logic        acc_clr = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  alu_exec_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .bus_a    (bus_a),
    .bus_b    (bus_b),
    .shamt    (shamt),
    .acc_clr  (acc_clr),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zr;
    logic        ovf;
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        mon_e = sb.pop_front();
        check("result",   {32'h0, result},   {32'h0, mon_e.res});
        check("zero",     {63'h0, zero},     {63'h0, mon_e.zr});
        check("overflow", {63'h0, overflow}, {63'h0, mon_e.ovf});
        check("hi",       {32'h0, hi},       {32'h0, mon_e.h});
        check("lo",       {32'h0, lo},       {32'h0, mon_e.l});
      end
    end
  end

  task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] exp_r, input logic exp_o);
    @(negedge clk);
    start    = 1'b1;
    alu_ctrl = ctrl;
    bus_a    = a;
    bus_b    = b;
    shamt    = sh;
    sb.push_back('{exp_r, (exp_r == 32'h0), exp_o, m_hi, m_lo});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
  endtask

`ifdef ALU_MULA_EN
  task automatic run_mula(input logic [31:0] a, input logic [31:0] b, input logic clr,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic inject);
    int n = 0;
    m_hi = exp_hi;
    m_lo = exp_lo;
    acc_clr = clr;
    issue(ALU_MULA, a, b, 5'd0, exp_lo, 1'b0);
    @(negedge clk);
    start   = 1'b0;
    acc_clr = 1'b0;
    while (busy && n < 100) begin
      n++;
      if (inject && n == 5) begin
        start = 1'b1; alu_ctrl = ALU_ADD; bus_a = 32'h5; bus_b = 32'h6; acc_clr = 1'b1;
      end
      if (inject && n == 6) begin
        start = 1'b0; acc_clr = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'd33);
    check("done_after_mula", {63'h0, done}, 64'd1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_result",   {32'h0, result}, 64'h0);
    check("rst_zero",     {63'h0, zero},   64'd1);
    check("rst_overflow", {63'h0, overflow}, 64'd0);
    check("rst_busy",     {63'h0, busy},   64'd0);
    check("rst_done",     {63'h0, done},   64'd0);
    check("rst_hilo",     {hi, lo},        64'h0);
    reset = 1'b0;

    // Back-to-back single-cycle ops, Start held high throughout.
    issue(ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1);
    issue(ALU_ADDU, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0);
    issue(ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0);
    issue(ALU_SUB,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1);
    issue(ALU_SUBU, 32'h00000005, 32'h00000007, 5'd0,  32'hFFFFFFFE, 1'b0);
    issue(ALU_SRA,  32'h0,        32'hF0000000, 5'd4,  32'hFF000000, 1'b0);
    issue(ALU_SRL,  32'h0,        32'hF0000000, 5'd4,  32'h0F000000, 1'b0);
    issue(ALU_SLL,  32'h0,        32'h00000001, 5'd31, 32'h80000000, 1'b0);
    issue(ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0);
    issue(ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0);
    issue(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0);
    issue(ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0);
    issue(ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0);
    issue(ALU_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 1'b0);
    issue(4'b1111,  32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h00000000, 1'b0);
    issue(ALU_LUI,  32'h0,        32'hABCD1234, 5'd0,  32'h12340000, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("done_drop",   {63'h0, done},   64'd0);
    check("result_hold", {32'h0, result}, 64'h12340000);
    @(negedge clk);
    check("result_hold2", {32'h0, result}, 64'h12340000);
    drain();

`ifdef ALU_MULA_EN
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    check("accclr_hilo", {hi, lo}, 64'h0);
    run_mula(32'hFFFFFFFF, 32'h00000002, 1'b0, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_mula(32'h00000001, 32'h00000002, 1'b0, 32'h00000002, 32'h00000000, 1'b1);
    run_mula(32'h00000003, 32'h00000004, 1'b1, 32'h00000000, 32'h0000000C, 1'b0);
    drain();

    // Reset in the middle of a multiply: abort with no Done.
    @(negedge clk);
    start = 1'b1; alu_ctrl = ALU_MULA; bus_a = 32'h3; bus_b = 32'h4;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_mul_busy", {63'h0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {63'h0, busy}, 64'd0);
    check("abort_hilo", {hi, lo},      64'h0);
    check("abort_done", {63'h0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    repeat (40) @(negedge clk);
    check("post_abort_busy", {63'h0, busy}, 64'd0);
`else
    issue(ALU_MULA, 32'h00000007, 32'h00000009, 5'd0, 32'h00000000, 1'b0);
    acc_clr = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    acc_clr = 1'b0;
    check("nomul_busy", {63'h0, busy}, 64'd0);
    check("nomul_done", {63'h0, done}, 64'd1);
    @(negedge clk);
    check("nomul_busy2", {63'h0, busy}, 64'd0);
    check("nomul_hilo",  {hi, lo},      64'h0);
`endif

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execute stage that consumes the 4-bit ALU control code from ALU control and performs the operation on the two register/immediate buses. All ops except MULA complete in one cycle. MULA is an iterative 32-cycle unsigned multiply-accumulate into a 64-bit HI/LO accumulator, signalled with a Start/Busy/Done handshake. The block sits between ALU control / operand muxing and the writeback/data-memory path.

## Interface
- Parameters: none. Data width is fixed at 32 bits.
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high; clears all state
- Start  input  1  request; sampled only when Busy=0
- ALUCtrl  input  4  operation code; encodings in shared defs
- BusA  input  32  operand A
- BusB  input  32  operand B / immediate
- Shamt  input  5  shift amount for SLL/SRL/SRA
- AccClr  input  1  clear HI/LO; honoured only when Busy=0
- Result  output  32  registered result
- Zero  output  1  registered (Result==0)
- Overflow  output  1  registered signed overflow (ADD/SUB only, else 0)
- Busy  output  1  high while a MULA is in progress
- Done  output  1  one-cycle pulse when Result is valid
- HI, LO  output  32 each  accumulator halves

## Operation
- Encodings: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, MULA 0101, SUB 0110, SLT 0111, ADDU 1000, SUBU 1001, XOR 1010, SLTU 1011, NOR 1100, SRA 1101, LUI 1110. Code 1111 is unused and gives Result=0.
- Basic ops:
  - Shifts: SLL = BusB<<Shamt; SRL is logical right; SRA is arithmetic right.
  - LUI = {BusB[15:0],16'h0}.
  - SLT is a signed compare and SLTU is unsigned; each gives 32'd1 or 32'd0.
  - Arithmetic is mod 2^32.
  - Overflow is set only for ADD/SUB on signed overflow. ADDU/SUBU never flag.
- FSM states: IDLE, MUL, ACC.
  - IDLE + Start + ALUCtrl!=MULA: register Result, Zero and Overflow; pulse Done. Stay in IDLE.
  - IDLE + Start + ALUCtrl==MULA: latch BusA and BusB, clear the product and the 5-bit counter, then go to MUL.
  - MUL: one shift-add step per cycle. The counter runs 0..31. At count 31, go to ACC.
  - ACC: {HI,LO} <= {HI,LO} + 64-bit product (wraps mod 2^64). Result <= new LO, Zero <= (new LO==0), Overflow <= 0. Pulse Done, then go to IDLE.
- Busy = (state != IDLE). Start while Busy is ignored, and so are changes to ALUCtrl, BusA and BusB; the latched operands are used.
- AccClr in IDLE zeroes HI/LO. If AccClr and a MULA Start arrive together, the clear is applied first, so the accumulation starts from 0. AccClr while Busy is ignored.
- Result, Zero and Overflow hold their values between operations.

## Timing
- Reset values: Result=0, Zero=1, Overflow=0, Busy=0, Done=0, HI=0, LO=0; state=IDLE.
- Single-cycle op: Start is sampled at edge N. Result and Done are valid after edge N. Done drops after edge N+1 unless another Start is sampled.
- Back-to-back single-cycle Starts give Done high continuously, with one result per cycle.
- MULA: Start is sampled at edge N. Busy is high from edge N to edge N+33. Result, HI, LO and Done update at edge N+33. Done is high for the cycle after N+33. A new Start is accepted at edge N+34 at the earliest.
- Reset asserted mid-MUL aborts the operation. It clears HI/LO and does not pulse Done.

## Configuration
- ALU_MULA_EN defined: the full MUL/ACC path, HI/LO accumulator and Busy are implemented.
- ALU_MULA_EN undefined:
  - MULA is treated as a single-cycle op with Result=0.
  - HI/LO and Busy are tied to 0, and AccClr is ignored.
  - The FSM reduces to IDLE only.

## Structure
- Shared header/package alu_defs holds the 4-bit ALUCtrl encodings listed above, shared with ALU control and its bench.
- Sub-module shift_add_multiplier: 32x32 unsigned iterative multiplier with 64-bit product and 5-bit counter, exposing start/step/last signals. It is instantiated only under ALU_MULA_EN.

## Test plan
- ADD with BusA=32'h7FFFFFFF, BusB=1 -> Result 32'h80000000, Overflow=1, Done=1 one cycle after Start. The same operands with ADDU -> Overflow=0.
- SRA with BusB=32'hF0000000, Shamt=4 -> Result 32'hFF000000. SRL on the same operands -> 32'h0F000000. LUI with BusB=16'h1234 -> 32'h12340000.
- SLT with BusA=32'hFFFFFFFF, BusB=1 -> Result 1. SLTU on the same operands -> 0, Zero=1.
- AccClr, then MULA 32'hFFFFFFFF x 2 -> Busy for 33 cycles, then HI=1, LO=32'hFFFFFFFE, Result=LO. A second MULA 1 x 2 -> LO=0, HI=2, Zero=1.
- Start=1 with ADD mid-MUL -> ignored, and the MULA result is unchanged. Reset at cycle 10 of MUL -> HI=LO=0, Busy=0, no Done pulse.
- ALU_MULA_EN undefined with a MULA Start -> Done the next cycle, Result=0, HI=LO=0, Busy never asserted.
